axi_lite_bram_slave: RTL and testbench

- AXI4-Lite responder (slave) that serves single-beat 32-bit reads and writes from the MIPS CPU AXI master port.
- Backed by a single-port synchronous BRAM with 1-cycle read latency.
- Used in full-simulation builds in the memory-responder slot, address bit 16 = 0.
- Also reusable behind the MMIO decode.

---
 rtl/axi_lite_bram_slave_if.sv | 36 +++
 rtl/axi_lite_bram_slave.sv | 142 ++++++++++++++
 tb/tb_axi_lite_bram_slave.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_bram_slave_if.sv
// rtl/axi_lite_bram_slave_if.sv - AXI4-Lite bus bundle between the CPU master and the BRAM responder
interface axi_lite_bram_slave_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic [3:0]            s_axi_wstrb;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axi_lite_bram_slave.sv
// rtl/axi_lite_bram_slave.sv - single-beat AXI4-Lite responder backed by a 1-cycle-latency BRAM
module axi_lite_bram_slave #(
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_WORDS_LOG2 = 14
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    axi_lite_bram_slave_if.slave      axi,
    output logic                      bram_en,
    output logic [3:0]                bram_we,
    output logic [MEM_WORDS_LOG2-1:0] bram_addr,
    output logic [31:0]               bram_wrdata,
    input  logic [31:0]               bram_rddata
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_RESP, WR_RESP} state_t;

    state_t                    state_q;
    logic                      aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0]     aw_addr_q;
    logic [31:0]               w_data_q;
    logic [3:0]                w_strb_q;
    logic                      rd_oor_q;
    logic                      rd_wait_q;
    logic                      bvalid_q, rvalid_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [31:0]               rdata_q;
    logic                      bram_en_q;
    logic [3:0]                bram_we_q;
    logic [MEM_WORDS_LOG2-1:0] bram_addr_q;
    logic [31:0]               bram_wrdata_q;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return |(a >> (MEM_WORDS_LOG2 + 2));
    endfunction

    // Readies are gated by reset so every output reads 0 while reset is held.
    logic awready, wready, arready;
    assign awready = s_axi_aresetn && !aw_held_q;
    assign wready  = s_axi_aresetn && !w_held_q;
    assign arready = s_axi_aresetn && (state_q == IDLE) && !(aw_held_q && w_held_q);

    logic aw_hs, w_hs, ar_hs, wr_oor;
    assign aw_hs  = axi.s_axi_awvalid && awready;
    assign w_hs   = axi.s_axi_wvalid && wready;
    assign ar_hs  = axi.s_axi_arvalid && arready;
    assign wr_oor = out_of_range(aw_addr_q);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q       <= IDLE;
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            rd_oor_q      <= 1'b0;
            rd_wait_q     <= 1'b0;
            bvalid_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= '0;
            bram_en_q     <= 1'b0;
            bram_we_q     <= '0;
            bram_addr_q   <= '0;
            bram_wrdata_q <= '0;
        end else begin
            bram_en_q <= 1'b0;
            bram_we_q <= '0;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= axi.s_axi_awaddr;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= axi.s_axi_wdata;
                w_strb_q <= axi.s_axi_wstrb;
            end
            case (state_q)
                IDLE: begin
                    if (aw_held_q && w_held_q) begin
                        bram_en_q     <= 1'b1;
                        bram_we_q     <= wr_oor ? 4'b0000 : w_strb_q;
                        bram_addr_q   <= aw_addr_q[MEM_WORDS_LOG2+1:2];
                        bram_wrdata_q <= w_data_q;
                        aw_held_q     <= 1'b0;
                        w_held_q      <= 1'b0;
                        bvalid_q      <= 1'b1;
                        bresp_q       <= wr_oor ? RESP_SLVERR : RESP_OKAY;
                        state_q       <= WR_RESP;
                    end else if (ar_hs) begin
                        bram_en_q   <= 1'b1;
                        bram_addr_q <= axi.s_axi_araddr[MEM_WORDS_LOG2+1:2];
                        rd_oor_q    <= out_of_range(axi.s_axi_araddr);
                        rd_wait_q   <= 1'b1;
                        state_q     <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    // First cycle: the BRAM samples the enable; second: its output is valid.
                    if (rd_wait_q) begin
                        rd_wait_q <= 1'b0;
                    end else begin
                        rdata_q  <= rd_oor_q ? 32'h0 : bram_rddata;
                        rresp_q  <= rd_oor_q ? RESP_SLVERR : RESP_OKAY;
                        rvalid_q <= 1'b1;
                        state_q  <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi.s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WR_RESP: begin
                    if (axi.s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi.s_axi_awready = awready;
    assign axi.s_axi_wready  = wready;
    assign axi.s_axi_arready = arready;
    assign axi.s_axi_bvalid  = bvalid_q;
    assign axi.s_axi_bresp   = bresp_q;
    assign axi.s_axi_rvalid  = rvalid_q;
    assign axi.s_axi_rresp   = rresp_q;
    assign axi.s_axi_rdata   = rdata_q;
    assign bram_en           = bram_en_q;
    assign bram_we           = bram_we_q;
    assign bram_addr         = bram_addr_q;
    assign bram_wrdata       = bram_wrdata_q;
endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// tb/tb_axi_lite_bram_slave.sv - table-driven bench for axi_lite_bram_slave with a behavioural BRAM
module tb_axi_lite_bram_slave;
    localparam int AW = 20;
    localparam int ML = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_bram_slave_if #(.ADDR_WIDTH(AW)) bus ();

    logic          bram_en;
    logic [3:0]    bram_we;
    logic [ML-1:0] bram_addr;
    logic [31:0]   bram_wrdata;
    logic [31:0]   bram_rddata = 32'h0;

    axi_lite_bram_slave #(.ADDR_WIDTH(AW), .MEM_WORDS_LOG2(ML)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .axi           (bus),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wrdata   (bram_wrdata),
        .bram_rddata   (bram_rddata)
    );

    logic [31:0] mem [0:(1<<ML)-1] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bram_en) begin
            bram_rddata <= mem[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
        end
    end

    int          en_cnt = 0;
    int          bv_rises = 0;
    logic        bv_prev = 1'b0;
    logic [3:0]  last_we = 4'h0;
    logic [ML-1:0] last_addr = '0;
    always @(posedge clk) begin
        if (bram_en) begin
            en_cnt   = en_cnt + 1;
            last_we  = bram_we;
            last_addr = bram_addr;
        end
        if (bus.s_axi_bvalid && !bv_prev) bv_rises = bv_rises + 1;
        bv_prev = bus.s_axi_bvalid;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        logic aw_go, w_go;
        int n;
        bus.s_axi_awaddr = a;  bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata  = d;  bus.s_axi_wstrb   = s;  bus.s_axi_wvalid = 1'b1;
        n = 0;
        while ((bus.s_axi_awvalid || bus.s_axi_wvalid) && n < 20) begin
            aw_go = bus.s_axi_awvalid && bus.s_axi_awready;
            w_go  = bus.s_axi_wvalid && bus.s_axi_wready;
            @(negedge clk); n++;
            if (aw_go) bus.s_axi_awvalid = 1'b0;
            if (w_go)  bus.s_axi_wvalid  = 1'b0;
        end
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        lat = 0;
        while (!bus.s_axi_bvalid && lat < 20) begin @(negedge clk); lat++; end
        resp = bus.s_axi_bresp;
        bus.s_axi_bready = 1'b1; @(negedge clk); bus.s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        logic go;
        int n;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        n = 0;
        while (bus.s_axi_arvalid && n < 20) begin
            go = bus.s_axi_arready;
            @(negedge clk); n++;
            if (go) bus.s_axi_arvalid = 1'b0;
        end
        bus.s_axi_arvalid = 1'b0;
        lat = 0;
        while (!bus.s_axi_rvalid && lat < 20) begin @(negedge clk); lat++; end
        d = bus.s_axi_rdata; resp = bus.s_axi_rresp;
        bus.s_axi_rready = 1'b1; @(negedge clk); bus.s_axi_rready = 1'b0;
    endtask

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;   // write data, or expected read data
        logic [3:0]    strb;
        logic [1:0]    resp;
        logic [3:0]    we;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        logic        bad;
        logic        oor;

        vecs[0]  = '{1'b1, 20'h00010, 32'hA5A5_1234, 4'hF, 2'b00, 4'hF};
        vecs[1]  = '{1'b0, 20'h00010, 32'hA5A5_1234, 4'h0, 2'b00, 4'h0};
        vecs[2]  = '{1'b1, 20'h00020, 32'h1122_3344, 4'hF, 2'b00, 4'hF};
        vecs[3]  = '{1'b1, 20'h00020, 32'hFFFF_FFFF, 4'h5, 2'b00, 4'h5};
        vecs[4]  = '{1'b0, 20'h00020, 32'h11FF_33FF, 4'h0, 2'b00, 4'h0};
        vecs[5]  = '{1'b1, 20'h00022, 32'hDEAD_BEEF, 4'h8, 2'b00, 4'h8};
        vecs[6]  = '{1'b0, 20'h00021, 32'hDEFF_33FF, 4'h0, 2'b00, 4'h0};
        vecs[7]  = '{1'b1, 20'h00030, 32'h1234_5678, 4'h0, 2'b00, 4'h0};
        vecs[8]  = '{1'b0, 20'h00030, 32'h0000_0000, 4'h0, 2'b00, 4'h0};
        vecs[9]  = '{1'b1, 20'h10000, 32'hCAFE_F00D, 4'hF, 2'b10, 4'h0};
        vecs[10] = '{1'b0, 20'h10000, 32'h0000_0000, 4'h0, 2'b10, 4'h0};
        vecs[11] = '{1'b0, 20'h00000, 32'h0000_0000, 4'h0, 2'b00, 4'h0};
        vecs[12] = '{1'b1, 20'h0FFFC, 32'h0BAD_CAFE, 4'hF, 2'b00, 4'hF};
        vecs[13] = '{1'b0, 20'h0FFFC, 32'h0BAD_CAFE, 4'h0, 2'b00, 4'h0};
        vecs[14] = '{1'b0, 20'h3FFFC, 32'h0000_0000, 4'h0, 2'b10, 4'h0};

        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0;  bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset readies", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 32'h0);
        chk("reset valids/resps", 32'({bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_bresp, bus.s_axi_rresp}), 32'h0);
        chk("reset rdata", bus.s_axi_rdata, 32'h0);
        chk("reset bram ctl", 32'({bram_en, bram_we, bram_addr}), 32'h0);
        chk("reset bram wrdata", bram_wrdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset readies", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 32'h7);

        // Table-driven single transactions
        for (int i = 0; i < NV; i++) begin
            en_cnt = 0;
            oor = (vecs[i].addr[AW-1:16] != '0);
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
                chk($sformatf("v%0d bresp", i), 32'(resp), 32'(vecs[i].resp));
                chk($sformatf("v%0d bvalid latency", i), 32'(lat), 32'd1);
            end else begin
                do_read(vecs[i].addr, rd, resp, lat);
                chk($sformatf("v%0d rdata", i), rd, vecs[i].data);
                chk($sformatf("v%0d rresp", i), 32'(resp), 32'(vecs[i].resp));
                chk($sformatf("v%0d rvalid latency", i), 32'(lat), 32'd2);
                chk($sformatf("v%0d rvalid cleared", i), 32'(bus.s_axi_rvalid), 32'h0);
            end
            chk($sformatf("v%0d bram_en pulses", i), 32'(en_cnt), 32'd1);
            chk($sformatf("v%0d bram_we", i), 32'(last_we), 32'(vecs[i].we));
            if (!oor) chk($sformatf("v%0d bram_addr", i), 32'(last_addr), 32'(vecs[i].addr[15:2]));
        end

        // AW leads W by three cycles
        en_cnt = 0; bv_rises = 0;
        bus.s_axi_awaddr = 20'h00040; bus.s_axi_awvalid = 1'b1;
        chk("skew awready before", 32'(bus.s_axi_awready), 32'h1);
        @(negedge clk); bus.s_axi_awvalid = 1'b0;
        chk("skew awready after", 32'(bus.s_axi_awready), 32'h0);
        repeat (3) @(negedge clk);
        chk("skew no early write", 32'(en_cnt), 32'd0);
        chk("skew no early bvalid", 32'(bus.s_axi_bvalid), 32'h0);
        bus.s_axi_wdata = 32'h600D_F00D; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        @(negedge clk); bus.s_axi_wvalid = 1'b0;
        lat = 0;
        while (!bus.s_axi_bvalid && lat < 20) begin @(negedge clk); lat++; end
        chk("skew bvalid latency", 32'(lat), 32'd1);
        bus.s_axi_bready = 1'b1; @(negedge clk); bus.s_axi_bready = 1'b0;
        repeat (3) @(negedge clk);
        chk("skew single write", 32'(en_cnt), 32'd1);
        chk("skew single bvalid", 32'(bv_rises), 32'd1);
        chk("skew bram_addr", 32'(last_addr), 32'h10);
        do_read(20'h00040, rd, resp, lat);
        chk("skew readback", rd, 32'h600D_F00D);

        // Read backpressure
        bus.s_axi_araddr = 20'h00010; bus.s_axi_arvalid = 1'b1;
        @(negedge clk); bus.s_axi_arvalid = 1'b0;
        lat = 0;
        while (!bus.s_axi_rvalid && lat < 20) begin @(negedge clk); lat++; end
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!bus.s_axi_rvalid || bus.s_axi_rdata !== 32'hA5A5_1234 ||
                bus.s_axi_rresp !== 2'b00 || bus.s_axi_arready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("rd backpressure stable", 32'(bad), 32'h0);
        bus.s_axi_rready = 1'b1; @(negedge clk); bus.s_axi_rready = 1'b0;
        chk("rd backpressure rvalid drop", 32'(bus.s_axi_rvalid), 32'h0);
        chk("rd backpressure arready back", 32'(bus.s_axi_arready), 32'h1);

        // Write-response backpressure
        bus.s_axi_awaddr = 20'h10050; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h1; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        @(negedge clk); bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        lat = 0;
        while (!bus.s_axi_bvalid && lat < 20) begin @(negedge clk); lat++; end
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!bus.s_axi_bvalid || bus.s_axi_bresp !== 2'b10 || bus.s_axi_arready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("wr backpressure stable", 32'(bad), 32'h0);
        bus.s_axi_bready = 1'b1; @(negedge clk); bus.s_axi_bready = 1'b0;
        chk("wr backpressure bvalid drop", 32'(bus.s_axi_bvalid), 32'h0);

        // Reset while the read is in RD_ISSUE
        bus.s_axi_araddr = 20'h00010; bus.s_axi_arvalid = 1'b1;
        @(negedge clk); bus.s_axi_arvalid = 1'b0;
        chk("midread bram_en issued", 32'(bram_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midread reset outputs", 32'({bus.s_axi_rvalid, bram_en, bus.s_axi_arready}), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.s_axi_rvalid || bus.s_axi_bvalid) bad = 1'b1;
        end
        chk("midread no stray response", 32'(bad), 32'h0);
        chk("midread arready idle", 32'(bus.s_axi_arready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
